// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR keystream sequencer: default widths and
// the sequencer FSM state encoding.
package lfsr_pkg;

    localparam int LFSR_W_DEF = 80;
    localparam int OUT_W_DEF  = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_VALID = 2'd3
    } state_t;

endpackage

// File: rtl/lfsr_seq_collect.sv
// Serial-to-parallel collector for the LFSR sequencer.
// Holds the shift-in word, the shift counter and the captured bit target.
// Optional LFSR_SEQ_PARITY_EN adds a running XOR of all collected bits.
module lfsr_seq_collect
    import lfsr_pkg::*;
#(
    parameter  int OUT_W = OUT_W_DEF,
    localparam int CNT_W = $clog2(OUT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [CNT_W-1:0] nbits,
    input  logic             shift,
    input  logic             ser_in,
    output logic [OUT_W-1:0] word,
    output logic             last
`ifdef LFSR_SEQ_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(OUT_W);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] target;

    // Capture the bit target on a new request; 0 (and anything above OUT_W) means a full word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target <= '0;
        end else if (clear) begin
            if (nbits == '0 || nbits > FULL) begin
                target <= FULL;
            end else begin
                target <= nbits;
            end
        end
    end

    // Shift counter: cleared per request, counts edges spent in SHIFT, stops at target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (shift) begin
            count <= count + ONE;
        end
    end

    // Shift-in register: first bit ends up at position target-1, unused upper bits stay 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word <= '0;
        end else if (clear) begin
            word <= '0;
        end else if (shift) begin
            word <= {word[OUT_W-2:0], ser_in};
        end
    end

    // Final shift of the request happens on the edge ending this cycle.
    always_comb begin
        last = shift && ((count + ONE) == target);
    end

`ifdef LFSR_SEQ_PARITY_EN
    // Running parity tracks the word: cleared per request, folded in on each shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity <= 1'b0;
        end else if (clear) begin
            parity <= 1'b0;
        end else if (shift) begin
            parity <= parity ^ ser_in;
        end
    end
`endif

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Sequencer for the 80-bit LFSR keystream datapath: per request loads a seed,
// runs the programmed number of shifts, and returns the packed serial output
// over a valid/ready handshake.
// Optional feature macro: LFSR_SEQ_PARITY_EN (adds word_parity output).
module lfsr_seq_ctrl
    import lfsr_pkg::*;
#(
    parameter  int LFSR_W = LFSR_W_DEF,
    parameter  int OUT_W  = OUT_W_DEF,
    localparam int CNT_W  = $clog2(OUT_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LFSR_W-1:0] seed,
    input  logic [CNT_W-1:0]  nbits,
    output logic              lfsr_par_load,
    output logic              lfsr_shift_en,
    output logic [LFSR_W-1:0] lfsr_seed,
    input  logic              lfsr_ser_out,
    output logic [OUT_W-1:0]  out_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
`ifdef LFSR_SEQ_PARITY_EN
    ,
    output logic              word_parity
`endif
);

    state_t state;
    state_t state_nxt;
    logic   accept;
    logic   last;

    // A request is taken from IDLE, or from VALID on the same edge the word is handed off.
    always_comb begin
        accept = start && ((state == S_IDLE) || ((state == S_VALID) && out_ready));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (last) begin
                    state_nxt = S_VALID;
                end
            end
            S_VALID: begin
                if (out_ready) begin
                    state_nxt = start ? S_LOAD : S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State-decoded outputs; all read 0 while reset holds the FSM in IDLE.
    always_comb begin
        lfsr_par_load = 1'b0;
        lfsr_shift_en = 1'b0;
        out_valid     = 1'b0;
        busy          = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_LOAD: begin
                lfsr_par_load = 1'b1;
                busy          = 1'b1;
            end
            S_SHIFT: begin
                lfsr_shift_en = 1'b1;
                busy          = 1'b1;
            end
            S_VALID: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Seed register drives the LFSR parallel-load bus; only changes on an accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_seed <= '0;
        end else if (accept) begin
            lfsr_seed <= seed;
        end
    end

    lfsr_seq_collect #(
        .OUT_W (OUT_W)
    ) u_collect (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .nbits  (nbits),
        .shift  (lfsr_shift_en),
        .ser_in (lfsr_ser_out),
        .word   (out_word),
        .last   (last)
`ifdef LFSR_SEQ_PARITY_EN
        ,
        .parity (word_parity)
`endif
    );

endmodule
